// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and helpers for the weight-stationary array sequencer.
// The default geometry here matches the array wrapper and the bench.
package systolic_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int KW_DEF   = 16;
  localparam int ROWS_DEF = 4;
  localparam int T_W      = KW_DEF + 2;
  localparam int LW       = $clog2(ROWS_DEF);

  // Last RUN time step: the final result leaves the bottom of column COLS-1.
  // A zero-length job degenerates to a single RUN cycle.
  function automatic int unsigned t_end_calc(input int unsigned k,
                                             input int unsigned rows,
                                             input int unsigned cols,
                                             input int unsigned pe_lat);
    int unsigned res;
    if (k == 32'd0) begin
      res = 32'd0;
    end else begin
      res = k - 32'd1 + cols - 32'd1 + rows * pe_lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the ROWS x COLS weight-stationary PE array: weight
// preload, accumulate phase with skewed left-edge valids, bottom-edge flags.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = 4,
  parameter int PE_LAT = 1,
  parameter int KW     = KW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     pe_mode,
  output logic                     w_rd_en,
  output logic [$clog2(ROWS)-1:0]  w_rd_addr,
  output logic                     a_rd_en,
  output logic [KW-1:0]            a_rd_addr,
  output logic [ROWS-1:0]          left_valid,
  output logic [COLS-1:0]          out_valid
);

  localparam int CNT_W  = KW + 2;
  localparam int ADDR_W = $clog2(ROWS);

  state_e             state_r;
  state_e             state_s;
  logic [ADDR_W-1:0]  l_r;
  logic [ADDR_W-1:0]  l_s;
  logic [CNT_W-1:0]   t_r;
  logic [CNT_W-1:0]   t_s;
  logic [KW-1:0]      k_r;
  logic [KW-1:0]      k_s;
  logic [CNT_W-1:0]   k_ext_s;
  logic [CNT_W-1:0]   t_end_s;
  logic               run_s;
  logic               load_s;
  logic               a_rd_en_s;
  logic [ROWS-1:0]    left_valid_s;
  logic [COLS-1:0]    out_valid_s;

  assign k_ext_s = {2'b00, k_s};
  assign t_end_s = CNT_W'(t_end_calc(32'(k_s), ROWS, COLS, PE_LAT));

  // Next state and counters; abort overrides both start and the normal exit.
  always_comb begin
    state_s = state_r;
    l_s     = l_r;
    t_s     = t_r;
    k_s     = k_r;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s = LOAD;
            l_s     = '0;
            t_s     = '0;
            k_s     = k_len;
          end else begin
            state_s = IDLE;
          end
        end
        LOAD: begin
          if (l_r == ADDR_W'(ROWS - 1)) begin
            state_s = RUN;
            t_s     = '0;
          end else begin
            l_s = l_r + 1'b1;
          end
        end
        RUN: begin
          if (t_r == t_end_s) begin
            state_s = IDLE;
          end else begin
            t_s = t_r + 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next-cycle state so they line up with it.
  assign run_s     = (state_s == RUN);
  assign load_s    = (state_s == LOAD);
  assign a_rd_en_s = run_s && (t_s < k_ext_s);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [CNT_W-1:0] R_OFF = CNT_W'(r);
    assign left_valid_s[r] = run_s && (t_s >= R_OFF) && ((t_s - R_OFF) < k_ext_s);
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam logic [CNT_W-1:0] C_OFF = CNT_W'(c + ROWS * PE_LAT);
    assign out_valid_s[c] = run_s && (t_s >= C_OFF) && ((t_s - C_OFF) < k_ext_s);
  end

  // State, counters and every output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      l_r        <= '0;
      t_r        <= '0;
      k_r        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pe_mode    <= 1'b0;
      w_rd_en    <= 1'b0;
      w_rd_addr  <= '0;
      a_rd_en    <= 1'b0;
      a_rd_addr  <= '0;
      left_valid <= '0;
      out_valid  <= '0;
    end else begin
      state_r    <= state_s;
      l_r        <= l_s;
      t_r        <= t_s;
      k_r        <= k_s;
      busy       <= (state_s != IDLE);
      done       <= run_s && (t_s == t_end_s);
      pe_mode    <= run_s;
      w_rd_en    <= load_s;
      w_rd_addr  <= load_s ? (ADDR_W'(ROWS - 1) - l_s) : '0;
      a_rd_en    <= a_rd_en_s;
      a_rd_addr  <= a_rd_en_s ? t_s[KW-1:0] : '0;
      left_valid <= left_valid_s;
      out_valid  <= out_valid_s;
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: cycle table for a basic job, hand-written
// corner sequences, and random traffic against a job-timeline model.
module tb_systolic_seq_ctrl;
  import systolic_seq_ctrl_pkg::*;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int PE_LAT = 1;
  localparam int KW     = 16;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [KW-1:0]     k_len;
  logic              busy, done, pe_mode, w_rd_en, a_rd_en;
  logic [LW-1:0]     w_rd_addr;
  logic [KW-1:0]     a_rd_addr;
  logic [ROWS-1:0]   left_valid;
  logic [COLS-1:0]   out_valid;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            pe_mode;
    logic            w_rd_en;
    logic [LW-1:0]   w_rd_addr;
    logic            a_rd_en;
    logic [KW-1:0]   a_rd_addr;
    logic [ROWS-1:0] left_valid;
    logic [COLS-1:0] out_valid;
  } outs_t;

  typedef struct {
    logic  st;
    int    k;
    outs_t exp;
  } vec_t;

  outs_t act;
  outs_t zero_o;
  vec_t  tbl [15];
  int    n_vec = 0;
  int    n_err = 0;

  // Model: a job is just its acceptance cycle and length; everything else is arithmetic.
  bit    m_on = 1'b0;
  int    m_s  = 0;
  int    m_k  = 0;
  int    cyc  = 0;

  systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .PE_LAT(PE_LAT), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .pe_mode(pe_mode), .w_rd_en(w_rd_en),
    .w_rd_addr(w_rd_addr), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .left_valid(left_valid), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  assign act = {busy, done, pe_mode, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr, left_valid, out_valid};

  function automatic int t_end_of(input int k);
    return (k == 0) ? 0 : (k - 1) + (COLS - 1) + ROWS * PE_LAT;
  endfunction

  function automatic bit model_active();
    return m_on && ((cyc - m_s) <= ROWS + 1 + t_end_of(m_k));
  endfunction

  function automatic outs_t model_out();
    outs_t o;
    int rel, t, te;
    o   = '0;
    te  = t_end_of(m_k);
    rel = cyc - m_s;
    if (m_on && rel >= 1 && rel <= ROWS) begin
      o.busy      = 1'b1;
      o.w_rd_en   = 1'b1;
      o.w_rd_addr = LW'(ROWS - rel);
    end else if (m_on && rel > ROWS && (rel - ROWS - 1) <= te) begin
      t         = rel - ROWS - 1;
      o.busy    = 1'b1;
      o.pe_mode = 1'b1;
      o.done    = (t == te);
      o.a_rd_en = (t < m_k);
      o.a_rd_addr = o.a_rd_en ? KW'(t) : '0;
      for (int r = 0; r < ROWS; r++) o.left_valid[r] = (t >= r) && (t < r + m_k);
      for (int c = 0; c < COLS; c++)
        o.out_valid[c] = (t >= c + ROWS * PE_LAT) && (t < c + ROWS * PE_LAT + m_k);
    end
    return o;
  endfunction

  function automatic outs_t mk(input logic b, d, p, we, input int wa, input logic ae,
                               input int aa, input logic [3:0] lv, ov);
    return {b, d, p, we, LW'(wa), ae, KW'(aa), lv, ov};
  endfunction

  task automatic check(input string name, input outs_t e);
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s cyc=%0d got busy=%b done=%b pe=%b wen=%b wa=%0d aen=%b aa=%0d lv=%b ov=%b | want busy=%b done=%b pe=%b wen=%b wa=%0d aen=%b aa=%0d lv=%b ov=%b",
               name, cyc, act.busy, act.done, act.pe_mode, act.w_rd_en, act.w_rd_addr, act.a_rd_en,
               act.a_rd_addr, act.left_valid, act.out_valid, e.busy, e.done, e.pe_mode, e.w_rd_en,
               e.w_rd_addr, e.a_rd_en, e.a_rd_addr, e.left_valid, e.out_valid);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One clock: drive inputs, advance the model with what the DUT samples, compare.
  task automatic step(input logic st, input logic ab, input logic rs, input int k);
    bit pre_active;
    start = st; abort = ab; rst = rs; k_len = KW'(k);
    pre_active = model_active();
    @(posedge clk);
    if (rs || ab) begin
      m_on = 1'b0;
    end else if (!pre_active && st) begin
      m_on = 1'b1;
      m_s  = cyc;
      m_k  = k;
    end
    cyc++;
    #1;
    check("model", model_out());
  endtask

  // Start a job and wait (bounded) for done; reports the done cycle relative to start.
  task automatic run_job(input int k, input int budget, output int dcyc, output int dcnt,
                         output bit anyv);
    dcyc = -1; dcnt = 0; anyv = 1'b0;
    step(1'b1, 1'b0, 1'b0, k);
    for (int i = 1; i <= budget; i++) begin
      if (done === 1'b1) begin
        dcnt++;
        if (dcyc < 0) dcyc = i;
      end
      anyv = anyv | a_rd_en | (|left_valid) | (|out_valid);
      if (busy !== 1'b1) break;
      step(1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    int  dcyc, dcnt;
    bit  anyv;
    zero_o = '0;

    tbl[0]  = '{1'b1, 3, mk(1, 0, 0, 1, 3, 0, 0, 4'b0000, 4'b0000)};
    tbl[1]  = '{1'b0, 0, mk(1, 0, 0, 1, 2, 0, 0, 4'b0000, 4'b0000)};
    tbl[2]  = '{1'b0, 0, mk(1, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000)};
    tbl[3]  = '{1'b0, 0, mk(1, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000)};
    tbl[4]  = '{1'b0, 0, mk(1, 0, 1, 0, 0, 1, 0, 4'b0001, 4'b0000)};
    tbl[5]  = '{1'b0, 0, mk(1, 0, 1, 0, 0, 1, 1, 4'b0011, 4'b0000)};
    tbl[6]  = '{1'b1, 7, mk(1, 0, 1, 0, 0, 1, 2, 4'b0111, 4'b0000)};
    tbl[7]  = '{1'b0, 0, mk(1, 0, 1, 0, 0, 0, 0, 4'b1110, 4'b0000)};
    tbl[8]  = '{1'b0, 0, mk(1, 0, 1, 0, 0, 0, 0, 4'b1100, 4'b0001)};
    tbl[9]  = '{1'b0, 0, mk(1, 0, 1, 0, 0, 0, 0, 4'b1000, 4'b0011)};
    tbl[10] = '{1'b0, 0, mk(1, 0, 1, 0, 0, 0, 0, 4'b0000, 4'b0111)};
    tbl[11] = '{1'b0, 0, mk(1, 0, 1, 0, 0, 0, 0, 4'b0000, 4'b1110)};
    tbl[12] = '{1'b0, 0, mk(1, 0, 1, 0, 0, 0, 0, 4'b0000, 4'b1100)};
    tbl[13] = '{1'b0, 0, mk(1, 1, 1, 0, 0, 0, 0, 4'b0000, 4'b1000)};
    tbl[14] = '{1'b1, 5, mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000)};

    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    check("reset", zero_o);
    step(1'b0, 1'b0, 1'b0, 0);

    // Basic k_len=3 job, with starts while busy and in the done cycle.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].st, 1'b0, 1'b0, tbl[i].k);
      check($sformatf("basic_c%0d", i + 1), tbl[i].exp);
    end

    // Weight preload only.
    run_job(0, 20, dcyc, dcnt, anyv);
    check_int("k0_done_cycle", dcyc, 5);
    check_int("k0_done_count", dcnt, 1);
    check_int("k0_no_valids", int'(anyv), 0);

    // Abort at RUN t=2, then a clean restart.
    step(1'b1, 1'b0, 1'b0, 8);
    repeat (6) step(1'b0, 1'b0, 1'b0, 0);
    check_int("abort_at_t2_addr", int'(a_rd_addr), 2);
    step(1'b0, 1'b1, 1'b0, 0);
    check("abort_idle", zero_o);
    dcnt = 0;
    repeat (12) begin
      step(1'b0, 1'b0, 1'b0, 0);
      if (done === 1'b1) dcnt++;
    end
    check_int("abort_no_done", dcnt, 0);
    run_job(2, 40, dcyc, dcnt, anyv);
    check_int("restart_done_cycle", dcyc, ROWS + 1 + t_end_of(2));

    // Reset mid-LOAD.
    step(1'b1, 1'b0, 1'b0, 5);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    check("rst_mid_load", zero_o);
    step(1'b0, 1'b0, 1'b0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0, $urandom_range(0, 200) == 0,
           ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6)));
    end
    step(1'b0, 1'b1, 1'b0, 0);

    // Long job whose end time exceeds KW bits.
    run_job(65533, 65600, dcyc, dcnt, anyv);
    check_int("long_done_cycle", dcyc, ROWS + 1 + t_end_of(65533));
    check_int("long_done_count", dcnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
